uart_rx: RTL and testbench

UART receiver for 8N1 serial frames on the RS-232 line, the receive-side counterpart of `uart_tx`. It synchronizes the asynchronous `rs232_rx` pin, qualifies the start bit, and samples each bit at mid-bit. It presents the received byte with a one-cycle `done` strobe, or a one-cycle `frame_err` strobe when the stop bit is bad. It sits between the board pin and the user logic that consumes received bytes.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_if.sv | 15 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : state encoding and bit-period derivation shared by uart_rx/uart_tx
// rev 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic int calc_bit_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// uart_rx_if : serial line in, received byte and status strobes out
// rev 1.0
// ============================================================================
interface uart_rx_if;
    logic       rs232_rx;
    logic [7:0] data;
    logic       done;
    logic       frame_err;

    modport master (output rs232_rx, input data, input done, input frame_err);
    modport slave  (input rs232_rx, output data, output done, output frame_err);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// uart_rx_sync : two-flop synchronizer plus falling-edge detector for the RX pin
// rev 1.0
// ============================================================================
module uart_rx_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_rx,
    output logic      o_rx_s2,
    output logic      o_fall
);
    logic r_rx_s1;
    logic r_rx_s2;
    logic r_rx_d;

    // Reset to the idle (high) level so release of reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= i_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign o_rx_s2 = r_rx_s2;
    assign o_fall  = r_rx_d & ~r_rx_s2;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// uart_rx : 8N1 UART receiver with mid-bit sampling, done / frame_err strobes
// rev 1.0
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int BIT_CNT  = calc_bit_cnt(CLK_FREQ, BAUD)
) (
    input  wire logic  clk,
    input  wire logic  rst,
    uart_rx_if.slave   rx_if
);
    localparam int CW = $clog2(BIT_CNT);
    localparam logic [CW-1:0] c_half_last = CW'(BIT_CNT / 2 - 1);
    localparam logic [CW-1:0] c_bit_last  = CW'(BIT_CNT - 1);

    logic w_rx_s2;
    logic w_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (rx_if.rs232_rx),
        .o_rx_s2 (w_rx_s2),
        .o_fall  (w_fall)
    );

    uart_state_t   r_state,   w_state_nxt;
    logic [CW-1:0] r_cnt,     w_cnt_nxt;
    logic [2:0]    r_bit_idx, w_bit_idx_nxt;
    logic [7:0]    r_sh,      w_sh_nxt;
    logic [7:0]    r_data,    w_data_nxt;
    logic          r_done,    w_done_nxt;
    logic          r_ferr,    w_ferr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_sh      <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_sh      <= w_sh_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + CW'(1);
        w_bit_idx_nxt = r_bit_idx;
        w_sh_nxt      = r_sh;
        w_data_nxt    = r_data;
        w_done_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = START;
            end
            START: begin
                // A line that is high again at mid start bit was a glitch
                if (r_cnt == c_half_last) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s2) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end
                end
            end
            DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt = '0;
                    w_sh_nxt  = {w_rx_s2, r_sh[7:1]};
                    if (r_bit_idx == 3'd7) w_state_nxt = STOP;
                    else                   w_bit_idx_nxt = r_bit_idx + 3'd1;
                end
            end
            STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s2) begin
                        w_data_nxt = r_sh;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rx_if.data      = r_data;
    assign rx_if.done      = r_done;
    assign rx_if.frame_err = r_ferr;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_rx : directed frames against uart_rx at 16 clocks per bit
// rev 1.0
// ============================================================================
module tb_uart_rx;
    import uart_pkg::*;

    localparam int B       = 16;
    localparam int LAT_EXP = 3 + B / 2 + 9 * B;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ (1_600_000),
        .BAUD     (100_000)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_done  = 0;
    int         n_ferr  = 0;
    int         n_wide  = 0;
    int         n_both  = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    logic       prev_done = 1'b0;
    logic       prev_ferr = 1'b0;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        n_done <= n_done + ((bus.done === 1'b1) ? 1 : 0);
        n_ferr <= n_ferr + ((bus.frame_err === 1'b1) ? 1 : 0);
        n_wide <= n_wide + ((bus.done === 1'b1 && prev_done === 1'b1) ? 1 : 0)
                         + ((bus.frame_err === 1'b1 && prev_ferr === 1'b1) ? 1 : 0);
        n_both <= n_both + ((bus.done === 1'b1 && bus.frame_err === 1'b1) ? 1 : 0);
        if (bus.done === 1'b1) begin
            done_cyc <= cyc;
            rx_log.push_back(bus.data);
        end
        prev_done <= bus.done;
        prev_ferr <= bus.frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        bus.rs232_rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        hold(1'b0, B);
        for (int i = 0; i < 8; i++) hold(b[i], B);
        hold(stop_bit, B);
    endtask

    logic [7:0] lb [3];
    int         lat;

    initial begin
        lb[0] = 8'h55; lb[1] = 8'h58; lb[2] = 8'hB8;
        bus.rs232_rx = 1'b1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_data", 32'(bus.data), 32'h00);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_ferr", 32'(bus.frame_err), 32'h0);
        hold(1'b1, 10000);
        chk("idle_no_done", n_done, 0);
        chk("idle_no_ferr", n_ferr, 0);

        for (int k = 0; k < 3; k++) begin
            send_frame(lb[k], 1'b1);
            lat = done_cyc - start_cyc;
            chk($sformatf("lat_%0d", k), 32'((lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1)), 32'h1);
            hold(1'b1, 2 * B);
        end
        chk("lb_count", n_done, 3);
        for (int k = 0; k < 3; k++) chk($sformatf("lb_data_%0d", k), 32'(rx_log[k]), 32'(lb[k]));
        chk("lb_data_port", 32'(bus.data), 32'hB8);

        hold(1'b0, 5);
        hold(1'b1, 3 * B);
        chk("glitch_done", n_done, 3);
        chk("glitch_ferr", n_ferr, 0);
        chk("glitch_idle", 32'(dut.r_state), 32'(IDLE));
        send_frame(8'hA3, 1'b1);
        hold(1'b1, 2 * B);
        chk("a3_count", n_done, 4);
        chk("a3_data", 32'(bus.data), 32'hA3);

        send_frame(8'h3C, 1'b0);
        hold(1'b0, 20 * B);
        hold(1'b1, 2 * B);
        chk("ferr_count", n_ferr, 1);
        chk("ferr_no_done", n_done, 4);
        chk("ferr_data_kept", 32'(bus.data), 32'hA3);
        send_frame(8'hC3, 1'b1);
        hold(1'b1, 2 * B);
        chk("c3_count", n_done, 5);
        chk("c3_data", 32'(bus.data), 32'hC3);

        hold(1'b0, B);
        hold(1'b1, 4 * B + B / 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        hold(1'b1, 12 * B);
        chk("mrst_done", n_done, 5);
        chk("mrst_ferr", n_ferr, 1);
        chk("mrst_data", 32'(bus.data), 32'h00);
        chk("mrst_idle", 32'(dut.r_state), 32'(IDLE));
        send_frame(8'h81, 1'b1);
        hold(1'b1, 2 * B);
        chk("x81_count", n_done, 6);
        chk("x81_data", 32'(bus.data), 32'h81);

        send_frame(8'h00, 1'b1);
        lat = done_cyc - start_cyc;
        chk("b2b_lat0", 32'((lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1)), 32'h1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 2 * B);
        chk("b2b_count", n_done, 8);
        chk("b2b_data0", 32'(rx_log[6]), 32'h00);
        chk("b2b_data1", 32'(rx_log[7]), 32'hFF);
        chk("b2b_ferr", n_ferr, 1);

        chk("strobe_width", n_wide, 0);
        chk("strobe_excl", n_both, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
